adsr_envelope: RTL

- Gate-driven attack/decay/sustain/release envelope generator.
- Sits directly upstream of the synth sources. Its `level` output drives the `volume` input of a source's volume scaler, replacing the fixed one-shot envelope.
- The envelope advances once per audio sample. A one-clk `sample_tick` strobe, derived from the LRCLK edge, enables each step.
- A sub-LSB fractional accumulator gives slow ramps without stair-step clicks.

---
 rtl/adsr_envelope.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/adsr_envelope.sv
// Gate-driven ADSR envelope generator.
// The envelope steps once per audio sample (sample_tick). A FRAC_BITS-wide
// fractional extension of the accumulator lets slow ramps move by less than one
// output LSB per sample, which avoids audible stair-steps. The output level is
// the integer part of the accumulator.
module adsr_envelope #(
   parameter int VOLUME_BITS = 8,
   parameter int FRAC_BITS   = 8,
   parameter int RATE_BITS   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sample_tick,
   input  logic                   gate,
   input  logic [RATE_BITS-1:0]   attack_rate,
   input  logic [RATE_BITS-1:0]   decay_rate,
   input  logic [VOLUME_BITS-1:0] sustain_level,
   input  logic [RATE_BITS-1:0]   release_rate,
   output logic [VOLUME_BITS-1:0] level,
   output logic                   level_valid,
   output logic                   active,
   output logic [2:0]             state_o
);

   localparam int W = VOLUME_BITS + FRAC_BITS;
   localparam logic [W-1:0] MAX = '1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } state_t;

   // Each step function returns {phase_done, new_acc}. Sums and limits are
   // formed one bit wider than the accumulator so they saturate instead of wrap.
   function automatic logic [W:0] attack_step(input logic [W-1:0] acc_in,
                                              input logic [W-1:0] rate);
      logic [W:0] sum;
      sum = {1'b0, acc_in} + {1'b0, rate};
      if (rate == '0 || sum >= {1'b0, MAX})
         attack_step = {1'b1, MAX};
      else
         attack_step = {1'b0, sum[W-1:0]};
   endfunction

   // acc - rate <= tgt is evaluated as acc <= tgt + rate, which cannot underflow.
   function automatic logic [W:0] decay_step(input logic [W-1:0] acc_in,
                                             input logic [W-1:0] rate,
                                             input logic [W-1:0] tgt);
      logic [W:0] lim;
      lim = {1'b0, tgt} + {1'b0, rate};
      if (acc_in <= tgt || rate == '0 || {1'b0, acc_in} <= lim)
         decay_step = {1'b1, tgt};
      else
         decay_step = {1'b0, acc_in - rate};
   endfunction

   function automatic logic [W:0] release_step(input logic [W-1:0] acc_in,
                                               input logic [W-1:0] rate);
      if (rate == '0 || acc_in <= rate)
         release_step = {1'b1, {W{1'b0}}};
      else
         release_step = {1'b0, acc_in - rate};
   endfunction

   state_t         state;
   state_t         nxt_state;
   logic [W-1:0]   acc;
   logic [W-1:0]   nxt_acc;
   logic           gate_q;
   logic           step_en;
   logic           rise;
   logic           fall;
   logic [W:0]     stp;
   logic [W-1:0]   a_ext;
   logic [W-1:0]   d_ext;
   logic [W-1:0]   r_ext;
   logic [W-1:0]   tgt;

   assign a_ext = W'(attack_rate);
   assign d_ext = W'(decay_rate);
   assign r_ext = W'(release_rate);
   assign tgt   = {sustain_level, {FRAC_BITS{1'b0}}};
   assign rise  = gate & ~gate_q;
   assign fall  = ~gate & gate_q;

   // Next state and accumulator: gate edges win over a tick and skip the step.
   always_comb begin
      nxt_state = state;
      nxt_acc   = acc;
      step_en   = 1'b0;
      stp       = '0;
      if (rise) begin
         nxt_state = ATTACK;
      end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
         nxt_state = RELEASE;
      end else if (sample_tick) begin
         step_en = 1'b1;
         unique case (state)
            IDLE: begin
               nxt_acc = '0;
            end
            ATTACK: begin
               stp     = attack_step(acc, a_ext);
               nxt_acc = stp[W-1:0];
               if (stp[W]) nxt_state = DECAY;
            end
            DECAY: begin
               stp     = decay_step(acc, d_ext, tgt);
               nxt_acc = stp[W-1:0];
               if (stp[W]) nxt_state = SUSTAIN;
            end
            SUSTAIN: begin
               nxt_acc = tgt;
            end
            RELEASE: begin
               stp     = release_step(acc, r_ext);
               nxt_acc = stp[W-1:0];
               if (stp[W]) nxt_state = IDLE;
            end
            default: begin
               nxt_state = IDLE;
               nxt_acc   = '0;
            end
         endcase
      end
   end

   // Envelope state, accumulator and registered status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         gate_q      <= 1'b0;
         level_valid <= 1'b0;
         active      <= 1'b0;
      end else begin
         state       <= nxt_state;
         acc         <= nxt_acc;
         gate_q      <= gate;
         level_valid <= step_en;
         active      <= (nxt_state != IDLE);
      end
   end

   assign level   = acc[W-1:FRAC_BITS];
   assign state_o = state;

endmodule
